// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding
// and flag bit positions. Build option: ALU_SEQ_MUL_EN (adds the MUL state).
package alu_pkg;

  localparam logic [2:0] ADD_OP  = 3'b000;
  localparam logic [2:0] SUB_OP  = 3'b001;
  localparam logic [2:0] NAND_OP = 3'b010;
  localparam logic [2:0] PASSA_OP = 3'b011;
  localparam logic [2:0] PASSB_OP = 3'b100;
  localparam logic [2:0] SHL_OP  = 3'b101;
  localparam logic [2:0] SHR_OP  = 3'b110;
  localparam logic [2:0] MUL_OP  = 3'b111;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  // Bit positions inside the packed flag vector
  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_ERR  = 4;
  localparam int NUM_FLAGS = 5;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one bit of b per cycle, WIDTH iterations.
// Only instantiated when ALU_SEQ_MUL_EN is defined. done is a one-cycle pulse
// registered after the last iteration; product is stable from then on.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  // Load operands on start, then add/shift once per cycle until all bits consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        acc_reg    <= '0;
        mcand_reg  <= a;
        mplier_reg <= b;
        cnt_reg    <= '0;
        busy_reg   <= 1'b1;
      end else if (busy_reg) begin
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and status flags.
// Build option: ALU_SEQ_MUL_EN compiles in the iterative multiplier; without
// it opcode 111 completes in one cycle with flag_err set and result 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);

  localparam int SHW = $clog2(WIDTH) + 1;

  state_t                 state_reg;
  state_t                 state_next;
  state_t                 accept_target;
  logic                   accept;
  logic [WIDTH-1:0]       result_reg;
  logic [NUM_FLAGS-1:0]   flags_reg;
  logic [WIDTH-1:0]       alu_res;
  logic [NUM_FLAGS-1:0]   alu_flags;
  logic [WIDTH:0]         add_full;
  logic [WIDTH:0]         sub_full;
  logic [SHW-2:0]         shamt;
  logic                   shift_oob;

  assign accept    = in_valid && in_ready;
  assign add_full  = {1'b0, op_a} + {1'b0, op_b};
  // Top bit of the extended difference is the unsigned borrow (a < b)
  assign sub_full  = {1'b0, op_a} - {1'b0, op_b};
  assign shamt     = op_b[SHW-2:0];
  // Any set bit at or above log2(WIDTH) means the shift amount is >= WIDTH
  assign shift_oob = |op_b[WIDTH-1:SHW-1];

`ifdef ALU_SEQ_MUL_EN
  logic             is_mul;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_mul        = (op_select == MUL_OP);
  assign accept_target = is_mul ? MUL : DONE;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign accept_target = DONE;
`endif

  // Single-cycle datapath: result and flags for every non-iterative opcode
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op_select)
      ADD_OP: begin
        alu_res           = add_full[WIDTH-1:0];
        alu_flags[FLAG_C] = add_full[WIDTH];
        alu_flags[FLAG_V] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                            (add_full[WIDTH-1] != op_a[WIDTH-1]);
      end
      SUB_OP: begin
        alu_res           = sub_full[WIDTH-1:0];
        alu_flags[FLAG_C] = sub_full[WIDTH];
        alu_flags[FLAG_V] = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                            (sub_full[WIDTH-1] != op_a[WIDTH-1]);
      end
      NAND_OP:  alu_res = ~(op_a & op_b);
      PASSA_OP: alu_res = op_a;
      PASSB_OP: alu_res = op_b;
      SHL_OP:   alu_res = shift_oob ? '0 : (op_a << shamt);
      SHR_OP:   alu_res = shift_oob ? '0 : (op_a >> shamt);
      MUL_OP: begin
        alu_res = '0;
`ifndef ALU_SEQ_MUL_EN
        alu_flags[FLAG_ERR] = 1'b1;
`endif
      end
      default: alu_res = '0;
    endcase
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = accept_target;
`ifdef ALU_SEQ_MUL_EN
      MUL:  if (mul_done && !mul_busy) state_next = DONE;
`endif
      DONE: if (out_ready) state_next = accept ? accept_target : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: a new op may enter in the same cycle the old result leaves
  always_comb begin
    out_valid = (state_reg == DONE);
    in_ready  = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  end

  // Result/flag register: loaded on single-cycle accept or multiplier completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_reg <= '0;
      flags_reg  <= '0;
`ifdef ALU_SEQ_MUL_EN
    end else if (accept && !is_mul) begin
      result_reg <= alu_res;
      flags_reg  <= alu_flags;
    end else if ((state_reg == MUL) && mul_done) begin
      result_reg          <= mul_product;
      flags_reg           <= '0;
      flags_reg[FLAG_Z]   <= (mul_product == '0);
      flags_reg[FLAG_N]   <= mul_product[WIDTH-1];
    end
`else
    end else if (accept) begin
      result_reg <= alu_res;
      flags_reg  <= alu_flags;
    end
`endif
  end

  assign result   = result_reg;
  assign flag_z   = flags_reg[FLAG_Z];
  assign flag_n   = flags_reg[FLAG_N];
  assign flag_c   = flags_reg[FLAG_C];
  assign flag_v   = flags_reg[FLAG_V];
  assign flag_err = flags_reg[FLAG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16). Expected results are queued at
// issue time; a negedge monitor pops and compares on every output handshake.
// Honours ALU_SEQ_MUL_EN for the multiplier expectations.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0]   op_select = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, flag_err;
  logic [4:0]   flags_vec;

  assign flags_vec = {flag_err, flag_v, flag_c, flag_n, flag_z};

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_select (op_select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_err  (flag_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   flags;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endfunction

  // Monitor: every output handshake pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid === 1'b1 && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got result 0x%0h flags 0x%0h, expected no output", result, flags_vec);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 32'(result), 32'(e.res));
        check("sb_flags", 32'(flags_vec), 32'(e.flags));
      end
    end
  end

  // Offer one op, wait (bounded) for the accept edge, then scramble inputs
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic [4:0] f, input bit push);
    int guard = 0;
    if (push) exp_q.push_back('{res: r, flags: f});
    op_select = op;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready low for %0d cycles, expected accept", guard);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    op_a      = 16'hDEAD;
    op_b      = 16'hBEEF;
    op_select = PASSA_OP;
  endtask

  initial begin
    int lat;
    int bad_ready;
    int n0;
    int stale;
    int guard;
    int exp_lat;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    check("out_valid_in_reset", 32'(out_valid), 32'd0);
    check("result_in_reset", 32'(result), 32'd0);
    check("flags_in_reset", 32'(flags_vec), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Single-cycle ops; flags are {err,v,c,n,z}
    issue(ADD_OP, 16'hFFFF, 16'h0001, 16'h0000, 5'b00101, 1'b1);
    check("add_latency_out_valid", 32'(out_valid), 32'd1);
    issue(SUB_OP,   16'h8000, 16'h0001, 16'h7FFF, 5'b01000, 1'b1);
    issue(SUB_OP,   16'h0001, 16'h0002, 16'hFFFF, 5'b00110, 1'b1);
    issue(SHL_OP,   16'h0001, 16'd16,   16'h0000, 5'b00001, 1'b1);
    issue(SHR_OP,   16'h8000, 16'd15,   16'h0001, 5'b00000, 1'b1);
    issue(NAND_OP,  16'hFFFF, 16'hFFFF, 16'h0000, 5'b00001, 1'b1);
    issue(PASSA_OP, 16'h8001, 16'h1234, 16'h8001, 5'b00010, 1'b1);
    issue(PASSB_OP, 16'h8001, 16'h1234, 16'h1234, 5'b00000, 1'b1);
    issue(SHL_OP,   16'h0003, 16'd4,    16'h0030, 5'b00000, 1'b1);
    issue(SHR_OP,   16'hFFFF, 16'h0100, 16'h0000, 5'b00001, 1'b1);
    issue(ADD_OP,   16'h7FFF, 16'h0001, 16'h8000, 5'b01010, 1'b1);

    // Multiplier latency and in_ready while busy
`ifdef ALU_SEQ_MUL_EN
    issue(MUL_OP, 16'h0123, 16'h0010, 16'h1230, 5'b00000, 1'b1);
    exp_lat = 17;
`else
    issue(MUL_OP, 16'h0123, 16'h0010, 16'h0000, 5'b10001, 1'b1);
    exp_lat = 0;
`endif
    lat = 0;
    bad_ready = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad_ready++;
      @(posedge clk); #1;
      lat++;
    end
    check("mul_latency_edges_after_accept", 32'(lat), 32'(exp_lat));
    check("mul_in_ready_while_busy", 32'(bad_ready), 32'd0);
    @(posedge clk); #1;

    // Backpressure: result held, in_ready low
    out_ready = 1'b0;
    issue(ADD_OP, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid_ready_result_flags",
            32'({out_valid, in_ready, result, flags_vec}),
            32'({1'b1, 1'b0, 16'h0005, 5'b00000}));
      @(posedge clk); #1;
    end

    // Release with four queued ADDs: one handshake per cycle
    n0 = hs_cyc.size();
    out_ready = 1'b1;
    issue(ADD_OP, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 1'b1);
    issue(ADD_OP, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010, 1'b1);
    issue(ADD_OP, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b00110, 1'b1);
    issue(ADD_OP, 16'h8000, 16'h8000, 16'h0000, 5'b01101, 1'b1);
    @(negedge clk); #1;
    check("throughput_handshakes", 32'(hs_cyc.size() - n0), 32'd5);
    if (hs_cyc.size() - n0 == 5)
      check("throughput_span_cycles", 32'(hs_cyc[n0 + 4] - hs_cyc[n0]), 32'd4);
    @(posedge clk); #1;

    // Reset in the middle of a multiply
`ifdef ALU_SEQ_MUL_EN
    issue(MUL_OP, 16'h0005, 16'h0007, 16'h0000, 5'b00000, 1'b0);
`else
    issue(MUL_OP, 16'h0005, 16'h0007, 16'h0000, 5'b10001, 1'b1);
`endif
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_mul_reset_outputs",
          32'({out_valid, in_ready, result, flags_vec}),
          32'({1'b0, 1'b0, 16'h0000, 5'b00000}));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (25) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    check("no_stale_result_cycles", 32'(stale), 32'd0);

    // Normal operation resumes
    issue(ADD_OP, 16'h1000, 16'h0234, 16'h1234, 5'b00000, 1'b1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
